noc_input_port: RTL and testbench
=================================

NOC_INPUT_PORT -- requirements
Module: noc_input_port

Interface
REQ-001 Parameter X_ID, default 0, meaning 4-bit X coordinate of this router.
REQ-002 Parameter Y_ID, default 0, meaning 4-bit Y coordinate of this router.
REQ-003 Parameter DEPTH, default 4, meaning flit buffer depth (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_i  input  16  incoming flit from upstream link.
REQ-007 valid_i  input  1  data_i carries a flit this cycle.
REQ-008 ready_o  output  1  port can accept a flit this cycle (buffer not full).
REQ-009 pop_req_i  input  1  crossbar consumes the head flit this cycle.
REQ-010 q_o  output  16  head flit, driven to the crossbar queue input.
REQ-011 address_route_o  output  3  output-port code for the head flit.
REQ-012 req_valid_o  output  1  head flit present (buffer not empty).
REQ-013 count_o  output  5  current occupancy, 0..DEPTH.
REQ-014 underflow_o  output  1  sticky flag, pop requested while empty.

Function
REQ-015 Flit format SHALL be dest_x [15:12], dest_y [11:8], payload [7:0]; single-flit packets only.
REQ-016 Push SHALL occur on a rising edge when valid_i=1 and ready_o=1; valid_i with ready_o=0 SHALL be ignored (no write, no state change).
REQ-017 ready_o SHALL equal (count_o != DEPTH), derived from registered state only.
REQ-018 Pop SHALL occur on a rising edge when pop_req_i=1 and req_valid_o=1.
REQ-019 pop_req_i=1 while req_valid_o=0 SHALL cause no pointer or count change and SHALL set underflow_o to 1 on that edge.
REQ-020 Simultaneous push and pop SHALL both take effect, count unchanged; when full, only the pop occurs since ready_o=0; when empty, only the push occurs and underflow_o is set.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL track occupancy separately to distinguish full from empty.
REQ-022 q_o SHALL be first-word-fall-through: head entry visible combinationally from registered storage, zero cycles after the push edge; q_o SHALL be 16'h0000 when empty.
REQ-023 address_route_o SHALL be XY routing on q_o: dest_x>X_ID -> EAST(2); dest_x<X_ID -> WEST(3); else dest_y>Y_ID -> NORTH(0); dest_y<Y_ID -> SOUTH(1); else LOCAL(4); all comparisons unsigned 4-bit.
REQ-024 address_route_o SHALL be LOCAL(4) when empty; codes 5..7 SHALL never be driven.
REQ-025 req_valid_o SHALL equal (count_o != 0).
REQ-026 Flits SHALL leave in arrival order; no flit is dropped, duplicated or reordered.

Reset
REQ-027 On rst=1 at a rising edge: pointers=0, count_o=0, underflow_o=0, hence ready_o=1, req_valid_o=0, q_o=0, address_route_o=4.
REQ-028 Reset mid-operation SHALL discard all buffered flits; push or pop in the reset cycle SHALL be ignored.
REQ-029 Storage array contents need not be reset.

Structure
REQ-030 Package noc_pkg SHALL hold the route-code enum (NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4), flit field bit positions, and FLIT_W=16.
REQ-031 Buffering SHALL be a sub-module flit_fifo (storage, pointers, count, underflow); noc_input_port SHALL add XY route computation and port mapping.

Verification
REQ-032 Reset then push 16'h21AB at X_ID=1,Y_ID=1 -> next cycle req_valid_o=1, q_o=16'h21AB, address_route_o=2 (EAST).
REQ-033 Push DEPTH=4 flits with no pops -> ready_o=0, count_o=4; a fifth valid_i is ignored; four pops return the first four flits in order.
REQ-034 Full buffer, valid_i and pop_req_i together -> one pop, no push, count_o=3, ready_o=1 next cycle.
REQ-035 Empty buffer, pop_req_i=1 -> count_o stays 0, underflow_o=1 and stays 1 until rst.
REQ-036 Routing sweep at X_ID=1,Y_ID=1 with heads 16'h0100, 16'h1200, 16'h1000, 16'h1100 -> codes 3, 0, 1, 4.
REQ-037 Push 3 flits, assert rst for one cycle -> count_o=0, req_valid_o=0, address_route_o=4; next push/pop sequence behaves as after power-up.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared flit layout, route codes and the XY routing function for the NoC router.
package noc_pkg;

    localparam int unsigned FLIT_W     = 16;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned ROUTE_W    = 3;
    localparam int unsigned COUNT_W    = 5;
    localparam int unsigned DEST_X_HI  = 15;
    localparam int unsigned DEST_X_LO  = 12;
    localparam int unsigned DEST_Y_HI  = 11;
    localparam int unsigned DEST_Y_LO  = 8;
    localparam int unsigned PAYLOAD_HI = 7;
    localparam int unsigned PAYLOAD_LO = 0;

    typedef enum logic [ROUTE_W-1:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        EAST  = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } route_e;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic route_e xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] x_id,
        input logic [COORD_W-1:0] y_id
    );
        route_e r;
        if (dest_x > x_id)      r = EAST;
        else if (dest_x < x_id) r = WEST;
        else if (dest_y > y_id) r = NORTH;
        else if (dest_y < y_id) r = SOUTH;
        else                    r = LOCAL;
        return r;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit buffer with explicit occupancy count and sticky underflow flag.
module flit_fifo
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = FLIT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               pop_req_i,
    output logic [W-1:0]       q_o,
    output logic               req_valid_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               underflow_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               underflow;
    logic               do_push;
    logic               do_pop;

    // Handshakes qualify only on registered occupancy; reset masks both.
    assign do_push = valid_i   && (count != FULL_CNT) && !rst;
    assign do_pop  = pop_req_i && (count != '0)       && !rst;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
            if (pop_req_i && (count == '0)) underflow <= 1'b1;
        end
    end

    assign count_o     = count;
    assign ready_o     = (count != FULL_CNT);
    assign req_valid_o = (count != '0);
    assign underflow_o = underflow;
    assign q_o         = req_valid_o ? mem[rd_ptr] : '0;

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers incoming flits and computes the XY output-port code of the head flit.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int unsigned X_ID  = 0,
    parameter int unsigned Y_ID  = 0,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FLIT_W-1:0]   data_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                pop_req_i,
    output logic [FLIT_W-1:0]   q_o,
    output logic [ROUTE_W-1:0]  address_route_o,
    output logic                req_valid_o,
    output logic [COUNT_W-1:0]  count_o,
    output logic                underflow_o
);

    localparam logic [COORD_W-1:0] X_COORD = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_COORD = COORD_W'(Y_ID);

    logic [FLIT_W-1:0] head;
    logic              head_valid;
    route_e            route;

    flit_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .pop_req_i   (pop_req_i),
        .q_o         (head),
        .req_valid_o (head_valid),
        .count_o     (count_o),
        .underflow_o (underflow_o)
    );

    // Empty buffer reports LOCAL regardless of this router's coordinates.
    always_comb begin
        route = LOCAL;
        if (head_valid) begin
            route = xy_route(head[DEST_X_HI:DEST_X_LO], head[DEST_Y_HI:DEST_Y_LO],
                             X_COORD, Y_COORD);
        end
    end

    assign q_o             = head;
    assign req_valid_o     = head_valid;
    assign address_route_o = route;

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at X_ID=1, Y_ID=1, DEPTH=4.
module tb_noc_input_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        pop_req_i = 1'b0;
    logic [15:0] q_o;
    logic [2:0]  address_route_o;
    logic        req_valid_o;
    logic [4:0]  count_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] flit;
        logic [2:0]  route;
    } exp_t;

    exp_t exp_q[$];

    noc_input_port #(
        .X_ID  (1),
        .Y_ID  (1),
        .DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .pop_req_i       (pop_req_i),
        .q_o             (q_o),
        .address_route_o (address_route_o),
        .req_valid_o     (req_valid_o),
        .count_o         (count_o),
        .underflow_o     (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one flit for one cycle; queue it for the monitor if it should be accepted.
    task automatic push(input logic [15:0] f, input logic [2:0] r, input bit accept);
        data_i  = f;
        valid_i = 1'b1;
        if (accept) exp_q.push_back('{flit: f, route: r});
        tick();
        valid_i = 1'b0;
    endtask

    task automatic pop_n(input int n);
        pop_req_i = 1'b1;
        repeat (n) tick();
        pop_req_i = 1'b0;
    endtask

    // Monitor: every consuming edge must present the next expected head flit and its route.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && pop_req_i && req_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_order: head %h presented, none expected", q_o);
            end else begin
                e = exp_q.pop_front();
                chk("head_flit", q_o, e.flit);
                chk("head_route", 16'(address_route_o), 16'(e.route));
            end
        end
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_count", 16'(count_o), 16'd0);
        chk("rst_ready", 16'(ready_o), 16'd1);
        chk("rst_req_valid", 16'(req_valid_o), 16'd0);
        chk("rst_q", q_o, 16'h0000);
        chk("rst_route", 16'(address_route_o), 16'd4);
        chk("rst_underflow", 16'(underflow_o), 16'd0);

        // Single flit falls through and routes EAST
        push(16'h21AB, 3'd2, 1'b1);
        chk("fwft_valid", 16'(req_valid_o), 16'd1);
        chk("fwft_q", q_o, 16'h21AB);
        chk("fwft_route", 16'(address_route_o), 16'd2);
        chk("fwft_count", 16'(count_o), 16'd1);
        pop_n(1);
        chk("drain1_count", 16'(count_o), 16'd0);

        // Fill with the routing sweep, overflow attempt, then drain in order
        push(16'h0100, 3'd3, 1'b1);
        push(16'h1200, 3'd0, 1'b1);
        push(16'h1000, 3'd1, 1'b1);
        push(16'h1100, 3'd4, 1'b1);
        chk("full_count", 16'(count_o), 16'd4);
        chk("full_ready", 16'(ready_o), 16'd0);
        push(16'h2FFF, 3'd2, 1'b0);
        chk("overflow_count", 16'(count_o), 16'd4);
        chk("overflow_head", q_o, 16'h0100);
        pop_n(4);
        chk("sweep_empty", 16'(count_o), 16'd0);
        chk("sweep_q_zero", q_o, 16'h0000);
        chk("sweep_no_underflow", 16'(underflow_o), 16'd0);

        // Full buffer with push and pop together: only the pop takes effect
        push(16'h3301, 3'd2, 1'b1);
        push(16'h0302, 3'd3, 1'b1);
        push(16'h1503, 3'd0, 1'b1);
        push(16'h1004, 3'd1, 1'b1);
        data_i = 16'h1111; valid_i = 1'b1; pop_req_i = 1'b1;
        tick();
        valid_i = 1'b0; pop_req_i = 1'b0;
        chk("fullpp_count", 16'(count_o), 16'd3);
        chk("fullpp_ready", 16'(ready_o), 16'd1);
        chk("fullpp_head", q_o, 16'h0302);
        pop_n(3);

        // Partial buffer with push and pop together: count unchanged
        push(16'h2222, 3'd2, 1'b1);
        exp_q.push_back('{flit: 16'h1105, route: 3'd4});
        data_i = 16'h1105; valid_i = 1'b1; pop_req_i = 1'b1;
        tick();
        valid_i = 1'b0; pop_req_i = 1'b0;
        chk("pp_count", 16'(count_o), 16'd1);
        chk("pp_route", 16'(address_route_o), 16'd4);
        pop_n(1);

        // Pop while empty sets sticky underflow without moving state
        pop_n(1);
        chk("uf_count", 16'(count_o), 16'd0);
        chk("uf_flag", 16'(underflow_o), 16'd1);
        exp_q.push_back('{flit: 16'h0A00, route: 3'd3});
        data_i = 16'h0A00; valid_i = 1'b1; pop_req_i = 1'b1;
        tick();
        valid_i = 1'b0; pop_req_i = 1'b0;
        chk("uf_push_count", 16'(count_o), 16'd1);
        chk("uf_push_route", 16'(address_route_o), 16'd3);
        chk("uf_sticky", 16'(underflow_o), 16'd1);
        pop_n(1);
        chk("uf_sticky2", 16'(underflow_o), 16'd1);

        // Reset mid-operation discards contents; push/pop during reset ignored
        push(16'h4401, 3'd2, 1'b0);
        push(16'h4402, 3'd2, 1'b0);
        push(16'h4403, 3'd2, 1'b0);
        chk("pre_rst_count", 16'(count_o), 16'd3);
        rst = 1'b1; data_i = 16'h4444; valid_i = 1'b1; pop_req_i = 1'b1;
        tick();
        rst = 1'b0; valid_i = 1'b0; pop_req_i = 1'b0;
        chk("mid_rst_count", 16'(count_o), 16'd0);
        chk("mid_rst_valid", 16'(req_valid_o), 16'd0);
        chk("mid_rst_route", 16'(address_route_o), 16'd4);
        chk("mid_rst_underflow", 16'(underflow_o), 16'd0);
        chk("mid_rst_ready", 16'(ready_o), 16'd1);
        push(16'h21AB, 3'd2, 1'b1);
        chk("post_rst_q", q_o, 16'h21AB);
        chk("post_rst_count", 16'(count_o), 16'd1);
        pop_n(1);
        chk("post_rst_empty", 16'(count_o), 16'd0);

        tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
